// File: rtl/sal_axi_mem_responder.sv
// AXI3 slave responder backed by a word-addressed array: independent write and
// read state machines share one memory; INCR/FIXED full-width bursts only.
module sal_axi_mem_responder #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int MEM_AW     = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [3:0]              awlen,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [3:0]              arlen,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(NB);
   localparam int DEPTH = 1 << MEM_AW;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

   w_state_t              w_state_r, w_state_s;
   logic [MEM_AW-1:0]     w_idx_r;
   logic [3:0]            w_len_r, w_cnt_r;
   logic                  w_incr_r, w_ill_r, w_err_r;
   logic                  awready_r, wready_r, bvalid_r;
   logic [ID_WIDTH-1:0]   bid_r;
   logic [1:0]            bresp_r;
   logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, w_beat_err_s, mem_we_s;

   r_state_t              r_state_r, r_state_s;
   logic [MEM_AW-1:0]     r_idx_r, ar_idx_s, r_next_idx_s;
   logic [3:0]            r_len_r, r_cnt_r;
   logic                  r_incr_r, r_ill_r, ar_ill_s;
   logic                  arready_r, rvalid_r, rlast_r;
   logic [ID_WIDTH-1:0]   rid_r;
   logic [1:0]            rresp_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  ar_hs_s, r_hs_s, r_last_beat_s;

   // Address bits outside the word index are deliberately ignored (aliasing).
   logic unused_addr_s;
   assign unused_addr_s = ^{awaddr[ADDR_WIDTH-1:MEM_AW+LSB], awaddr[LSB-1:0],
                            araddr[ADDR_WIDTH-1:MEM_AW+LSB], araddr[LSB-1:0]};

   assign aw_hs_s       = awvalid & awready_r;
   assign w_hs_s        = wvalid & wready_r;
   assign b_hs_s        = bvalid_r & bready;
   assign w_last_beat_s = (w_cnt_r == w_len_r);
   assign w_beat_err_s  = (wlast != w_last_beat_s);
   assign mem_we_s      = w_hs_s & ~w_ill_r;

   assign ar_hs_s       = arvalid & arready_r;
   assign r_hs_s        = rvalid_r & rready;
   assign r_last_beat_s = (r_cnt_r == r_len_r);
   assign ar_idx_s      = araddr[MEM_AW+LSB-1:LSB];
   assign ar_ill_s      = arburst[1];
   assign r_next_idx_s  = r_incr_r ? (r_idx_r + IDX_ONE) : r_idx_r;

   // Write FSM next-state decode
   always_comb begin
      w_state_s = w_state_r;
      case (w_state_r)
         W_IDLE: if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
         W_DATA: if (w_hs_s && w_last_beat_s) w_state_s = W_RESP; else w_state_s = W_DATA;
         W_RESP: if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
         default: w_state_s = W_IDLE;
      endcase
   end

   // Write FSM state, burst context and registered AW/W/B outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_r <= W_IDLE;
         w_idx_r   <= {MEM_AW{1'b0}};
         w_len_r   <= 4'd0;
         w_cnt_r   <= 4'd0;
         w_incr_r  <= 1'b0;
         w_ill_r   <= 1'b0;
         w_err_r   <= 1'b0;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bid_r     <= {ID_WIDTH{1'b0}};
         bresp_r   <= RESP_OKAY;
      end else begin
         w_state_r <= w_state_s;
         awready_r <= (w_state_s == W_IDLE);
         wready_r  <= (w_state_s == W_DATA);
         bvalid_r  <= (w_state_s == W_RESP);
         if (aw_hs_s) begin
            bid_r    <= awid;
            w_idx_r  <= awaddr[MEM_AW+LSB-1:LSB];
            w_len_r  <= awlen;
            w_incr_r <= (awburst == BURST_INCR);
            w_ill_r  <= awburst[1];
            w_cnt_r  <= 4'd0;
            w_err_r  <= 1'b0;
         end else if (w_hs_s) begin
            w_cnt_r <= w_cnt_r + 4'd1;
            w_err_r <= w_err_r | w_beat_err_s;
            if (w_incr_r) w_idx_r <= w_idx_r + IDX_ONE;
            // The burst length, not wlast, closes the burst; a mismatch only flags SLVERR.
            if (w_last_beat_s)
               bresp_r <= (w_ill_r | w_err_r | w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Byte-enabled array write; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) mem_r[w_idx_r][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Read FSM next-state decode
   always_comb begin
      r_state_s = r_state_r;
      case (r_state_r)
         R_IDLE: if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
         R_DATA: if (r_hs_s && r_last_beat_s) r_state_s = R_IDLE; else r_state_s = R_DATA;
         default: r_state_s = R_IDLE;
      endcase
   end

   // Read FSM state, burst context and registered R-channel beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_r <= R_IDLE;
         r_idx_r   <= {MEM_AW{1'b0}};
         r_len_r   <= 4'd0;
         r_cnt_r   <= 4'd0;
         r_incr_r  <= 1'b0;
         r_ill_r   <= 1'b0;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rid_r     <= {ID_WIDTH{1'b0}};
         rresp_r   <= RESP_OKAY;
         rdata_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         r_state_r <= r_state_s;
         arready_r <= (r_state_s == R_IDLE);
         rvalid_r  <= (r_state_s == R_DATA);
         if (ar_hs_s) begin
            rid_r    <= arid;
            r_idx_r  <= ar_idx_s;
            r_len_r  <= arlen;
            r_incr_r <= (arburst == BURST_INCR);
            r_ill_r  <= ar_ill_s;
            r_cnt_r  <= 4'd0;
            rlast_r  <= (arlen == 4'd0);
            rresp_r  <= ar_ill_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r  <= ar_ill_s ? {DATA_WIDTH{1'b0}} : mem_r[ar_idx_s];
         end else if (r_hs_s && !r_last_beat_s) begin
            r_idx_r <= r_next_idx_s;
            r_cnt_r <= r_cnt_r + 4'd1;
            rlast_r <= ((r_cnt_r + 4'd1) == r_len_r);
            rdata_r <= r_ill_r ? {DATA_WIDTH{1'b0}} : mem_r[r_next_idx_s];
         end
      end
   end

   assign awready = awready_r;
   assign wready  = wready_r;
   assign bvalid  = bvalid_r;
   assign bid     = bid_r;
   assign bresp   = bresp_r;
   assign arready = arready_r;
   assign rvalid  = rvalid_r;
   assign rid     = rid_r;
   assign rdata   = rdata_r;
   assign rresp   = rresp_r;
   assign rlast   = rlast_r;

endmodule

// File: tb/tb_sal_axi_mem_responder.sv
// Self-checking bench for sal_axi_mem_responder: randomized AXI bursts against
// a plain array model of the responder's golden memory.
module tb_sal_axi_mem_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   awid = 4'd0, arid = 4'd0, bid, rid;
   logic [31:0]  awaddr = 32'd0, araddr = 32'd0;
   logic [3:0]   awlen = 4'd0, arlen = 4'd0;
   logic [1:0]   awburst = 2'd0, arburst = 2'd0, bresp, rresp;
   logic         awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic [127:0] wdata = 128'd0, rdata;
   logic [15:0]  wstrb = 16'd0;
   logic         bvalid, bready = 1'b0, arvalid = 1'b0, arready;
   logic         rlast, rvalid, rready = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [127:0] model_mem [1024];
   logic [127:0] wd [16];
   logic [15:0]  ws [16];
   logic [127:0] rq_data [$];
   logic [1:0]   rq_resp [$];
   logic         rq_last [$];
   logic [3:0]   rq_id   [$];
   logic [127:0] eq [$];

   sal_axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Reference: apply a write burst to the model array, return expected BRESP.
   task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input int last_pos, output logic [1:0] exp_resp);
      logic [9:0] idx;
      idx = addr[13:4];
      for (int i = 0; i <= len; i++) begin
         if (!burst[1])
            for (int b = 0; b < 16; b++)
               if (ws[i][b]) model_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
         if (burst == 2'b01) idx = idx + 10'd1;
      end
      exp_resp = (burst[1] || last_pos != len) ? 2'b10 : 2'b00;
   endtask

   task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
      logic [9:0] idx;
      idx = addr[13:4];
      eq.delete();
      for (int i = 0; i <= len; i++) begin
         eq.push_back(burst[1] ? 128'd0 : model_mem[idx]);
         if (burst == 2'b01) idx = idx + 10'd1;
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int last_pos, input int b_hold,
                            output logic [1:0] resp, output logic [3:0] id_o);
      int n;
      resp = 2'bxx;
      id_o = 4'bxxxx;
      awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      if (awready !== 1'b1) begin
         errors++; checks++;
         $display("FAIL aw_wait: awready=%b required 1", awready);
         awvalid = 1'b0;
         return;
      end
      tick();
      awvalid = 1'b0;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b1) begin
         errors++;
         $display("FAIL aw_timing: awready=%b wready=%b required 0 1", awready, wready);
      end
      for (int i = 0; i <= len; i++) begin
         wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_pos); wvalid = 1'b1;
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b1) begin
         errors++;
         $display("FAIL w_end: wready=%b bvalid=%b required 0 1", wready, bvalid);
      end
      for (int c = 0; c < b_hold; c++) begin
         tick();
         checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0) begin
            errors++;
            $display("FAIL b_hold: bvalid=%b awready=%b required 1 0", bvalid, awready);
         end
      end
      resp = bresp;
      id_o = bid;
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if (awready !== 1'b1 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL b_done: awready=%b bvalid=%b required 1 0", awready, bvalid);
      end
   endtask

   function automatic logic rr_pattern(input int mode, input int cyc);
      case (mode)
         1: return !(cyc == 1 || cyc == 2);
         2: return 1'($urandom_range(0, 1));
         default: return 1'b1;
      endcase
   endfunction

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode);
      int n, cyc;
      logic done, stalled, p_last;
      logic [127:0] p_data;
      logic [1:0] p_resp;
      logic [3:0] p_id;
      rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete();
      arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < 50) begin tick(); n++; end
      if (arready !== 1'b1) begin
         errors++; checks++;
         $display("FAIL ar_wait: arready=%b required 1", arready);
         arvalid = 1'b0;
         return;
      end
      tick();
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || arready !== 1'b0) begin
         errors++;
         $display("FAIL ar_timing: rvalid=%b arready=%b required 1 0", rvalid, arready);
      end
      done = 1'b0; stalled = 1'b0; cyc = 0;
      p_data = 128'd0; p_resp = 2'd0; p_id = 4'd0; p_last = 1'b0;
      while (!done && cyc < 200) begin
         rready = rr_pattern(mode, cyc);
         if (stalled) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== p_data || rlast !== p_last ||
                rresp !== p_resp || rid !== p_id) begin
               errors++;
               $display("FAIL r_stable: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                        rvalid, rdata, rlast, p_data, p_last);
            end
         end
         if (rvalid === 1'b1 && rready) begin
            rq_data.push_back(rdata); rq_resp.push_back(rresp);
            rq_last.push_back(rlast); rq_id.push_back(rid);
            if (rlast === 1'b1) done = 1'b1;
            stalled = 1'b0;
         end else begin
            stalled = (rvalid === 1'b1);
            p_data = rdata; p_resp = rresp; p_id = rid; p_last = rlast;
         end
         tick();
         cyc++;
      end
      rready = 1'b0;
      if (!done) begin
         errors++; checks++;
         $display("FAIL r_timeout: beats=%0d required %0d", rq_data.size(), len + 1);
      end
      checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL r_end: arready=%b rvalid=%b required 1 0", arready, rvalid);
      end
   endtask

   // Compare the collected read beats with the model expectation.
   task automatic check_read(input string name, input logic [3:0] id, input int len,
                             input logic [1:0] exp_resp);
      checks++;
      if (rq_data.size() != len + 1) begin
         errors++;
         $display("FAIL %s_beats: got %0d required %0d", name, rq_data.size(), len + 1);
      end
      for (int i = 0; i < rq_data.size() && i <= len; i++) begin
         checks++;
         if (rq_data[i] !== eq[i] || rq_last[i] !== (i == len) ||
             rq_resp[i] !== exp_resp || rq_id[i] !== id) begin
            errors++;
            $display("FAIL %s_beat%0d: data=%h last=%b resp=%b id=%h required %h %b %b %h",
                     name, i, rq_data[i], rq_last[i], rq_resp[i], rq_id[i],
                     eq[i], (i == len), exp_resp, id);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'd0 ||
          {bresp, rresp} !== 4'd0 || rdata !== 128'd0 || {bid, rid} !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b rdata=%h required all 0",
                  awready, wready, bvalid, arready, rvalid, rdata);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (awready !== 1'b1 || arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: awready=%b arready=%b required 1 1", awready, arready);
      end
   endtask

   task automatic test_single();
      logic [1:0] r, er;
      logic [3:0] b;
      wd[0] = {16{8'hA5}}; ws[0] = 16'hFFFF;
      model_write(32'h100, 0, 2'b01, 0, er);
      axi_write(4'h3, 32'h100, 0, 2'b01, 0, 0, r, b);
      checks++;
      if (r !== er || r !== 2'b00 || b !== 4'h3) begin
         errors++;
         $display("FAIL single_b: bresp=%b bid=%h required 00 3", r, b);
      end
      model_read(32'h100, 0, 2'b01);
      axi_read(4'h5, 32'h100, 0, 2'b01, 0);
      check_read("single", 4'h5, 0, 2'b00);
   endtask

   task automatic test_incr_wrap();
      logic [1:0] r, er;
      logic [3:0] b;
      logic [31:0] a;
      a = {$urandom_range(0, 255), 24'd0} | {18'd0, 10'h3FF, 4'h0};
      for (int i = 0; i < 4; i++) begin wd[i] = rand128(); ws[i] = 16'hFFFF; end
      model_write(a, 3, 2'b01, 3, er);
      axi_write(4'h1, a, 3, 2'b01, 3, 0, r, b);
      checks++;
      if (r !== er) begin
         errors++; $display("FAIL wrap_b: bresp=%b required %b", r, er);
      end
      model_read(32'h3FF0, 3, 2'b01);
      axi_read(4'h2, 32'h3FF0, 3, 2'b01, 0);
      check_read("wrap", 4'h2, 3, 2'b00);
      // Word 0 must hold beat 1, proving the index wrapped.
      checks++;
      if (rq_data.size() > 1 && rq_data[1] !== wd[1]) begin
         errors++; $display("FAIL wrap_word0: got %h required %h", rq_data[1], wd[1]);
      end
   endtask

   task automatic test_fixed_strobe();
      logic [1:0] r, er;
      logic [3:0] b;
      logic [31:0] a;
      logic [127:0] exp_w;
      a = {18'd0, 10'($urandom_range(16, 900)), 4'h0};
      wd[0] = rand128(); ws[0] = 16'h00FF;
      wd[1] = rand128(); ws[1] = 16'hFF00;
      exp_w = {wd[1][127:64], wd[0][63:0]};
      model_write(a, 1, 2'b00, 1, er);
      axi_write(4'h7, a, 1, 2'b00, 1, 0, r, b);
      checks++;
      if (r !== 2'b00) begin
         errors++; $display("FAIL fixed_b: bresp=%b required 00", r);
      end
      axi_read(4'h8, a, 0, 2'b01, 0);
      checks++;
      if (rq_data.size() != 1 || rq_data[0] !== exp_w) begin
         errors++;
         $display("FAIL fixed_word: got %h required %h", rq_data.size() ? rq_data[0] : 128'd0, exp_w);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] r, er;
      logic [3:0] b;
      for (int i = 0; i < 4; i++) begin wd[i] = rand128(); ws[i] = 16'hFFFF; end
      model_write(32'h2000, 3, 2'b01, 3, er);
      axi_write(4'hA, 32'h2000, 3, 2'b01, 3, 5, r, b);
      checks++;
      if (r !== er || b !== 4'hA) begin
         errors++; $display("FAIL bp_b: bresp=%b bid=%h required %b a", r, b, er);
      end
      model_read(32'h2000, 3, 2'b01);
      axi_read(4'hB, 32'h2000, 3, 2'b01, 1);
      check_read("bp", 4'hB, 3, 2'b00);
   endtask

   task automatic test_errors();
      logic [1:0] r, er;
      logic [3:0] b;
      wd[0] = rand128(); ws[0] = 16'hFFFF;
      model_write(32'h3000, 0, 2'b01, 0, er);
      axi_write(4'h1, 32'h3000, 0, 2'b01, 0, 0, r, b);
      for (int i = 0; i < 2; i++) begin wd[i] = rand128(); ws[i] = 16'hFFFF; end
      model_write(32'h3000, 1, 2'b10, 1, er);
      axi_write(4'h2, 32'h3000, 1, 2'b10, 1, 0, r, b);
      checks++;
      if (r !== 2'b10) begin
         errors++; $display("FAIL wrap_burst_b: bresp=%b required 10", r);
      end
      model_read(32'h3000, 0, 2'b01);
      axi_read(4'h3, 32'h3000, 0, 2'b01, 0);
      check_read("wrap_unchanged", 4'h3, 0, 2'b00);

      for (int i = 0; i < 4; i++) begin wd[i] = rand128(); ws[i] = 16'hFFFF; end
      model_write(32'h3100, 3, 2'b01, 1, er);
      axi_write(4'h4, 32'h3100, 3, 2'b01, 1, 0, r, b);
      checks++;
      if (r !== er || r !== 2'b10) begin
         errors++; $display("FAIL early_wlast_b: bresp=%b required 10", r);
      end
      model_read(32'h3100, 3, 2'b01);
      axi_read(4'h5, 32'h3100, 3, 2'b01, 0);
      check_read("early_wlast", 4'h5, 3, 2'b00);

      model_read(32'h3100, 2, 2'b11);
      axi_read(4'h6, 32'h3100, 2, 2'b11, 2);
      check_read("rsvd_read", 4'h6, 2, 2'b10);
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] r, er;
      logic [3:0] b;
      for (int i = 0; i < 4; i++) begin wd[i] = rand128(); ws[i] = 16'hFFFF; end
      model_write(32'h4000, 3, 2'b01, 3, er);
      axi_write(4'h9, 32'h4000, 3, 2'b01, 3, 0, r, b);
      arid = 4'hC; araddr = 32'h4000; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      rready = 1'b1;
      tick();
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== wd[2]) begin
         errors++; $display("FAIL mid_beat2: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, wd[2]);
      end
      rst = 1'b1;
      tick();
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b0) begin
         errors++; $display("FAIL mid_reset: rvalid=%b arready=%b required 0 0", rvalid, arready);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (arready !== 1'b1) begin
         errors++; $display("FAIL mid_release: arready=%b required 1", arready);
      end
      model_read(32'h4000, 3, 2'b01);
      axi_read(4'hD, 32'h4000, 3, 2'b01, 0);
      check_read("after_reset", 4'hD, 3, 2'b00);
   endtask

   task automatic test_random();
      logic [1:0] r, er, burst;
      logic [3:0] b, id;
      logic [31:0] a;
      int len;
      for (int t = 0; t < 8; t++) begin
         a = $urandom();
         len = $urandom_range(0, 15);
         burst = $urandom_range(0, 1) ? 2'b01 : 2'b00;
         id = 4'($urandom_range(0, 15));
         for (int i = 0; i <= len; i++) begin
            wd[i] = rand128();
            ws[i] = (burst == 2'b00 && i > 0) ? 16'($urandom()) : 16'hFFFF;
         end
         model_write(a, len, burst, len, er);
         axi_write(id, a, len, burst, len, $urandom_range(0, 2), r, b);
         checks++;
         if (r !== er || b !== id) begin
            errors++; $display("FAIL rand%0d_b: bresp=%b bid=%h required %b %h", t, r, b, er, id);
         end
         model_read(a, len, burst);
         axi_read(~id, a, len, burst, 2);
         check_read($sformatf("rand%0d", t), ~id, len, 2'b00);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr_wrap();
      test_fixed_strobe();
      test_backpressure();
      test_errors();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sal_axi_mem_responder.md
# sal_axi_mem_responder

AXI slave responder answering the controller testbench's AXI initiator on the slave-side AW/W/B/AR/R channel set. Backed by an internal word-addressed register array, it gives the bench a cycle-accurate golden memory: writes land in the array, reads return it. The write and read paths are independent state machines sharing one array. The block supports the AXI3 burst subset used by the bench: 4-bit LEN, INCR/FIXED, full-width size only.

## Interface
- ID_WIDTH, 4, AXI ID width on all channels
- ADDR_WIDTH, 32, AXI byte address width
- DATA_WIDTH, 128, data width; byte lanes = DATA_WIDTH/8
- MEM_AW, 10, log2 of array depth in DATA_WIDTH words
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/4/2  write address fields
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data fields; wid is ignored
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1, bready in 1  B handshake
- arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/4/2  read address fields
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data fields
- rvalid out 1, rready in 1  R handshake

## Operation
- Word index = addr[MEM_AW+LSB-1:LSB], where LSB = log2(DATA_WIDTH/8). Upper address bits are ignored, so the index aliases modulo depth. Low LSB bits are ignored.
- Burst handling: INCR (01) adds 1 to the index per beat and wraps modulo 2^MEM_AW. FIXED (00) holds the index constant. WRAP (10) and reserved (11) are illegal.
- Write FSM has three states:
  - W_IDLE: awready=1. On AW handshake, latch id, index, len, burst and illegal flag; beat counter=0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the array with byte-enable wstrb, unless the burst is illegal.
    - At counter==len the burst ends regardless of wlast; go to W_RESP. Otherwise counter+1.
    - Set an error flag if wlast≠(counter==len) on any beat.
  - W_RESP: bvalid=1, bid=latched id. bresp=SLVERR (10) if the burst is illegal or the wlast error flag is set, else OKAY (00). On bready, return to W_IDLE.
- Read FSM has two states:
  - R_IDLE: arready=1. On AR handshake, latch id, index, len, burst and illegal flag; load first beat into the rdata register; go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(counter==len).
    - rresp=SLVERR with rdata=0 for illegal bursts, else OKAY.
    - On rready, advance the index and counter and load the next word. After the last beat, return to R_IDLE.
- Outputs rdata/rresp/rlast/rid are registered and held stable while rvalid=1 and rready=0.
- Read/write collision: if the same word is written and loaded into rdata in the same cycle, rdata gets the pre-write value.

## Timing
- Reset: while rst=1, all outputs are 0 (awready, wready, bvalid, arready, rvalid, bresp, rresp, rlast, rdata, ids). FSMs go to IDLE and counters to 0. The array contents are not reset.
- First cycle after rst falls: awready=1 and arready=1.
- AW handshake at cycle N: wready=1 from N+1, awready=0 from N+1.
- Last W beat at cycle M: wready=0 and bvalid=1 from M+1. B handshake at cycle K: awready=1 from K+1.
- AR handshake at cycle N: rvalid=1 with beat 0 at N+1. With rready held high, one beat per cycle, so a LEN=L burst ends at N+1+L. arready=1 the cycle after the rlast handshake.
- No outstanding transactions beyond one write and one read. The two channels run concurrently.
- Reset asserted mid-burst: the next cycle is IDLE with outputs zeroed. Partial writes already committed remain in the array.

## Test plan
- Single write then read: AW addr 0x100, len 0, INCR; W data 0xA5..., wstrb all 1 -> B OKAY at M+1. AR addr 0x100 -> rdata matches, rlast=1, rvalid at N+1.
- INCR burst wrap: AW addr at the last word (index 1023), len 3 -> words 1023, 0, 1, 2 written. A readback burst from 1023 returns the same four beats with rlast on beat 3.
- Strobes and FIXED: two beats to one word with wstrb 0x00FF then 0xFF00 -> the word holds the low bytes of beat 0 and the high bytes of beat 1.
- Backpressure: rready toggles 1,0,0,1 during a len 3 read -> rdata/rlast stable during stalls, exactly 4 beats delivered. bready held 0 for 5 cycles -> bvalid held, awready stays 0.
- Errors: awburst=WRAP -> array unchanged, bresp=10. wlast on beat 1 of a len 3 burst -> 4 beats accepted, bresp=10. arburst=11 -> rresp=10, rdata=0 on all beats.
- Reset mid-read: rst asserted during beat 2 of 4 -> rvalid=0 the next cycle, arready=1 the cycle after rst falls, and a new read completes normally.
